display_timing_480p: RTL and testbench
======================================

Name: display_timing_480p

Overview:
- Generates 640x480 @ 60 Hz VGA/DVI display timing from a 25.2 MHz pixel clock.
- Outputs signed screen coordinates, hsync/vsync, data-enable, and per-line and per-frame start pulses.
- Sits between the pixel-clock generator and all pixel pipelines (sprites, starfields, ROM DMA).
- Coordinates are signed: blanking is negative, the active area is 0..639 x 0..479. Consumers schedule work in blanking by comparing against negative sx.

Parameters:
- CORDW, 16, width of signed coordinate outputs; must be >= 11.
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_RES, 480, active lines per frame.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- H_POL, 0, hsync polarity (0 = active-low).
- V_POL, 0, vsync polarity (0 = active-low).

Ports:
- clk_pix  in  1  pixel clock; all logic on the rising edge.
- rst_pix_n  in  1  reset, synchronous, active-low.
- sx  out  CORDW signed  horizontal position.
- sy  out  CORDW signed  vertical position.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- de  out  1  data enable, high in the active area.
- frame  out  1  one-cycle pulse at the first pixel of a frame.
- line  out  1  one-cycle pulse at the first pixel of every line.

Behaviour:
- Derived constants:
  - H_STA = -(H_FP+H_SYNC+H_BP) = -160; HS_STA = H_STA+H_FP = -144; HS_END = HS_STA+H_SYNC = -48; HA_END = H_RES-1 = 639.
  - V_STA = -(V_FP+V_SYNC+V_BP) = -45; VS_STA = -35; VS_END = -33; VA_END = 479.
- Internal counters x, y (signed CORDW):
  - x increments each cycle.
  - At HA_END, x wraps to H_STA. If y == VA_END, y wraps to V_STA; otherwise y increments.
  - Period: 800 clocks per line, 525 lines per frame (420000 clocks).
- All outputs are registered from the current x, y (one-cycle latency); sx/sy equal the x/y that produced the other outputs in the same cycle.
  - hsync = H_POL ? in_hs : !in_hs, where in_hs = (HS_STA <= x < HS_END).
  - vsync is the same form, using y against VS_STA/VS_END and V_POL.
  - de = (x >= 0) && (y >= 0).
  - line = (x == H_STA).
  - frame = (x == H_STA) && (y == V_STA).
- Reset (rst_pix_n low at a clock edge):
  - Sets x = H_STA, y = V_STA.
  - Outputs: sx = H_STA, sy = V_STA, hsync = !H_POL, vsync = !V_POL, de = 0, line = 0, frame = 0.
  - Reset mid-frame abandons the current position immediately; no partial-line completion.
- The first edge after reset release outputs sx = -160, sy = -45, line = 1, frame = 1, and the counters advance.
- hsync and vsync are independent; the vsync window is aligned to line starts (changes only when x wraps).
- Exactly one frame pulse per 420000 clocks and one line pulse per 800 clocks. The frame pulse always coincides with a line pulse.

Optional Feature:
- Macro DISPLAY_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt (16 bits, unsigned).
  - Reset value is 0.
  - Increments on the clock edge at which frame is asserted; wraps 65535 -> 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package display_pkg holds:
  - 480p timing defaults and the CORDW default;
  - typedef coord_t (logic signed [15:0]).
- One natural sub-module: display_counter. It holds the x/y counters with wrap logic and is instantiated once.
- Sync, de and pulse decode stay in the top module.

Test Plan:
- Hold rst_pix_n = 0 for 5 cycles, then release -> first output sx = -160, sy = -45, frame = 1, line = 1; during reset hsync = vsync = 1 and de = 0.
- Run one line -> hsync low for exactly 96 clocks, starting at sx = -144 and ending after sx = -49; line pulses are 800 clocks apart.
- Run one full frame -> vsync low while sy is -35 and -34 (2 lines, 1600 clocks); next frame pulse 420000 clocks after the first.
- Check de -> high for 640 consecutive clocks per active line, 480 lines per frame (307200 clocks), low whenever sx < 0 or sy < 0.
- Assert reset at sx = 300, sy = 200 -> next output sx = -160, sy = -45; the first edge after release gives frame = 1.
- With DISPLAY_FRAME_CNT_EN defined, run 3 frames -> frame_cnt reads 3 after the third frame pulse; it is 0 after reset.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared 640x480 @ 60 Hz timing defaults, the default signed
//                coordinate width and the coordinate type used by the display
//                timing generator and its downstream pixel pipelines.
//  Contents    : CORDW_DEF, H_*_DEF / V_*_DEF timing defaults, coord_t,
//                blank_start() helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Signed coordinate width; must hold -160 .. 639 at minimum (>= 11 bits).
  localparam int CORDW_DEF = 16;

  // Horizontal timing (pixels)
  localparam int H_RES_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  // Vertical timing (lines)
  localparam int V_RES_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef logic signed [15:0] coord_t;

  // Blanking is mapped to negative coordinates, so the first coordinate of a
  // line/frame is minus the total blanking length.
  function automatic int blank_start(input int fp, input int sync, input int bp);
    return -(fp + sync + bp);
  endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_counter.sv
`default_nettype none
// ============================================================================
//  Module      : display_counter
//  Description : Signed x/y raster position counters. x runs H_STA..HA_END
//                and wraps to H_STA; y steps once per x wrap and runs
//                V_STA..VA_END before wrapping to V_STA.
//  Ports       : clk_pix_i   - pixel clock, rising edge
//                rst_pix_n_i - synchronous active-low reset
//                x_o / y_o   - current raster position (signed, CORDW bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module display_counter
  import display_pkg::*;
#(
  parameter int CORDW  = CORDW_DEF,
  parameter int H_STA  = -160,
  parameter int HA_END = 639,
  parameter int V_STA  = -45,
  parameter int VA_END = 479
) (
  input  logic                    clk_pix_i,
  input  logic                    rst_pix_n_i,
  output logic signed [CORDW-1:0] x_o,
  output logic signed [CORDW-1:0] y_o
);

  localparam logic signed [CORDW-1:0] C_H_STA  = CORDW'(H_STA);
  localparam logic signed [CORDW-1:0] C_HA_END = CORDW'(HA_END);
  localparam logic signed [CORDW-1:0] C_V_STA  = CORDW'(V_STA);
  localparam logic signed [CORDW-1:0] C_VA_END = CORDW'(VA_END);
  localparam logic signed [CORDW-1:0] C_ONE    = CORDW'(1);

  logic signed [CORDW-1:0] x_q, x_d;
  logic signed [CORDW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q + C_ONE;
    y_d = y_q;
    if (x_q == C_HA_END) begin
      x_d = C_H_STA;
      y_d = (y_q == C_VA_END) ? C_V_STA : (y_q + C_ONE);
    end
  end

  // Reset drops the position straight back to the top-left of blanking;
  // an interrupted line is simply abandoned.
  always_ff @(posedge clk_pix_i) begin
    if (!rst_pix_n_i) begin
      x_q <= C_H_STA;
      y_q <= C_V_STA;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule : display_counter
`default_nettype wire

// File: rtl/display_timing_480p.sv
`default_nettype none
// ============================================================================
//  Module      : display_timing_480p
//  Description : 640x480 @ 60 Hz VGA/DVI timing generator for a 25.2 MHz
//                pixel clock. Produces signed screen coordinates (blanking is
//                negative), hsync/vsync, data enable and line/frame start
//                pulses, all registered with one cycle of latency so that
//                sx/sy always match the other outputs of the same cycle.
//  Ports       : clk_pix   - pixel clock, rising edge
//                rst_pix_n - synchronous active-low reset
//                sx, sy    - signed position of the current output pixel
//                hsync     - horizontal sync (polarity H_POL)
//                vsync     - vertical sync (polarity V_POL)
//                de        - data enable, high in the active area
//                frame     - one-cycle pulse at the first pixel of a frame
//                line      - one-cycle pulse at the first pixel of each line
//                frame_cnt - 16-bit frame counter (DISPLAY_FRAME_CNT_EN only)
//  Build option: define DISPLAY_FRAME_CNT_EN to add the frame_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_timing_480p
  import display_pkg::*;
#(
  parameter int CORDW  = CORDW_DEF,
  parameter int H_RES  = H_RES_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line
`ifdef DISPLAY_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  // Derived timing points
  localparam int H_STA  = blank_start(H_FP, H_SYNC, H_BP);
  localparam int HS_STA = H_STA + H_FP;
  localparam int HS_END = HS_STA + H_SYNC;
  localparam int HA_END = H_RES - 1;
  localparam int V_STA  = blank_start(V_FP, V_SYNC, V_BP);
  localparam int VS_STA = V_STA + V_FP;
  localparam int VS_END = VS_STA + V_SYNC;
  localparam int VA_END = V_RES - 1;

  localparam logic signed [CORDW-1:0] C_H_STA  = CORDW'(H_STA);
  localparam logic signed [CORDW-1:0] C_HS_STA = CORDW'(HS_STA);
  localparam logic signed [CORDW-1:0] C_HS_END = CORDW'(HS_END);
  localparam logic signed [CORDW-1:0] C_V_STA  = CORDW'(V_STA);
  localparam logic signed [CORDW-1:0] C_VS_STA = CORDW'(VS_STA);
  localparam logic signed [CORDW-1:0] C_VS_END = CORDW'(VS_END);

  // --------------------------------------------------------------------------
  // Raster position
  // --------------------------------------------------------------------------
  logic signed [CORDW-1:0] w_x;
  logic signed [CORDW-1:0] w_y;

  display_counter #(
    .CORDW  (CORDW),
    .H_STA  (H_STA),
    .HA_END (HA_END),
    .V_STA  (V_STA),
    .VA_END (VA_END)
  ) u_counter (
    .clk_pix_i   (clk_pix),
    .rst_pix_n_i (rst_pix_n),
    .x_o         (w_x),
    .y_o         (w_y)
  );

  // --------------------------------------------------------------------------
  // Decode of the current position into next-cycle outputs
  // --------------------------------------------------------------------------
  logic w_in_hs;
  logic w_in_vs;
  logic hsync_d, vsync_d, de_d, line_d, frame_d;

  always_comb begin
    w_in_hs = (w_x >= C_HS_STA) && (w_x < C_HS_END);
    // y only changes when x wraps, so the vsync window is line-aligned.
    w_in_vs = (w_y >= C_VS_STA) && (w_y < C_VS_END);
    hsync_d = H_POL ? w_in_hs : !w_in_hs;
    vsync_d = V_POL ? w_in_vs : !w_in_vs;
    // Active area is exactly the non-negative quadrant: test the sign bits.
    de_d    = !w_x[CORDW-1] && !w_y[CORDW-1];
    line_d  = (w_x == C_H_STA);
    frame_d = line_d && (w_y == C_V_STA);
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic signed [CORDW-1:0] sx_q, sy_q;
  logic                    hsync_q, vsync_q, de_q, line_q, frame_q;

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      sx_q    <= C_H_STA;
      sy_q    <= C_V_STA;
      hsync_q <= !H_POL;
      vsync_q <= !V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sx_q    <= w_x;
      sy_q    <= w_y;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign line  = line_q;
  assign frame = frame_q;

`ifdef DISPLAY_FRAME_CNT_EN
  // --------------------------------------------------------------------------
  // Frame counter: counts on the edge that closes each frame pulse, so it
  // reads N once the N-th pulse has been seen. Wraps naturally at 16 bits.
  // --------------------------------------------------------------------------
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule : display_timing_480p
`default_nettype wire

// File: tb/tb_display_timing_480p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_timing_480p
//  Description : Self-checking bench for display_timing_480p. The active area
//                is shrunk (64 x 8) to keep frames short; all porch and sync
//                widths keep their 480p values, so blanking coordinates match
//                the full-size mode. A reference raster model pushes expected
//                outputs into a queue at every clock edge; they are popped and
//                compared on the following falling edge. Directed checks on
//                sync widths, pulse spacing and data-enable counts are derived
//                straight from the timing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_timing_480p;

  localparam int CORDW  = 16;
  localparam int H_RES  = 64;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_RES  = 8;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam bit H_POL  = 1'b0;
  localparam bit V_POL  = 1'b0;

  localparam int H_STA     = -(H_FP + H_SYNC + H_BP);   // -160
  localparam int HS_STA    = H_STA + H_FP;              // -144
  localparam int HS_END    = HS_STA + H_SYNC;           // -48
  localparam int HA_END    = H_RES - 1;
  localparam int V_STA     = -(V_FP + V_SYNC + V_BP);   // -45
  localparam int VS_STA    = V_STA + V_FP;              // -35
  localparam int VS_END    = VS_STA + V_SYNC;           // -33
  localparam int VA_END    = V_RES - 1;
  localparam int LINE_LEN  = H_RES + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LEN = LINE_LEN * (V_RES + V_FP + V_SYNC + V_BP);

  typedef struct packed {
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic               hs;
    logic               vs;
    logic               de;
    logic               frame;
    logic               line;
  } obs_t;

  logic                    clk_pix   = 1'b0;
  logic                    rst_pix_n = 1'b0;
  logic signed [CORDW-1:0] sx, sy;
  logic                    hsync, vsync, de, frame, line;
`ifdef DISPLAY_FRAME_CNT_EN
  logic [15:0]             frame_cnt;
`endif

  display_timing_480p #(
    .CORDW (CORDW), .H_RES (H_RES), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_RES (V_RES), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .H_POL (H_POL), .V_POL (V_POL)
  ) dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .sx        (sx),
    .sy        (sy),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .frame     (frame),
    .line      (line)
`ifdef DISPLAY_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  // Scoreboard and statistics
  obs_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mx, my;
  int   cyc = 0;
  int   last_line, last_frame, hs_run, vs_run, de_run, de_frame;
  int   frames_seen, vs_runs, hs_runs;
  int   prev_sx;
  bit   de_frame_valid;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t model_out(input int x, input int y);
    obs_t o;
    logic in_hs, in_vs;
    in_hs   = (x >= HS_STA) && (x < HS_END);
    in_vs   = (y >= VS_STA) && (y < VS_END);
    o.sx    = 16'(x);
    o.sy    = 16'(y);
    o.hs    = H_POL ? in_hs : !in_hs;
    o.vs    = V_POL ? in_vs : !in_vs;
    o.de    = (x >= 0) && (y >= 0);
    o.line  = (x == H_STA);
    o.frame = (x == H_STA) && (y == V_STA);
    return o;
  endfunction

  task automatic clear_stats();
    last_line = -1; last_frame = -1; hs_run = 0; vs_run = 0; de_run = 0;
    de_frame = 0; de_frame_valid = 1'b0; frames_seen = 0; vs_runs = 0; hs_runs = 0;
  endtask

  // One clock: model the edge, queue the expectation, compare on the falling edge.
  task automatic step();
    obs_t e, g;
    bit   run;
    @(posedge clk_pix);
    run = rst_pix_n;
    if (!run) begin
      e.sx = 16'(H_STA); e.sy = 16'(V_STA);
      e.hs = !H_POL; e.vs = !V_POL; e.de = 1'b0; e.frame = 1'b0; e.line = 1'b0;
      mx = H_STA; my = V_STA;
    end else begin
      e = model_out(mx, my);
      if (mx == HA_END) begin
        mx = H_STA;
        my = (my == VA_END) ? V_STA : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    q.push_back(e);
    @(negedge clk_pix);
    cyc++;
    g = '{sx: sx, sy: sy, hs: hsync, vs: vsync, de: de, frame: frame, line: line};
    e = q.pop_front();
    checks++;
    assert (g === e) else begin
      failures++;
      $error("FAIL scoreboard cyc=%0d observed=%h expected=%h", cyc, g, e);
    end
    if (!run) begin
      clear_stats();
    end else begin
      if (line) begin
        if (last_line >= 0) chk("line_gap", cyc - last_line, LINE_LEN);
        last_line = cyc;
      end
      if (frame) begin
        chk("frame_has_line", line, 1);
        if (last_frame >= 0) chk("frame_gap", cyc - last_frame, FRAME_LEN);
        if (de_frame_valid) chk("de_per_frame", de_frame, H_RES * V_RES);
        last_frame = cyc; de_frame = 0; de_frame_valid = 1'b1; frames_seen++;
      end
      if (hsync == H_POL) begin
        if (hs_run == 0) chk("hs_start_sx", sx, HS_STA);
        hs_run++;
      end else if (hs_run != 0) begin
        chk("hs_width", hs_run, H_SYNC);
        chk("hs_last_sx", prev_sx, HS_END - 1);
        hs_run = 0; hs_runs++;
      end
      if (vsync == V_POL) begin
        if (vs_run == 0) chk("vs_start_sy", sy, VS_STA);
        vs_run++;
      end else if (vs_run != 0) begin
        chk("vs_width", vs_run, V_SYNC * LINE_LEN);
        vs_run = 0; vs_runs++;
      end
      if (de) begin
        de_run++; de_frame++;
      end else if (de_run != 0) begin
        chk("de_run", de_run, H_RES);
        de_run = 0;
      end
      prev_sx = sx;
    end
  endtask

  initial begin
    bit found;
    int npulse;
    clear_stats();
    mx = H_STA; my = V_STA;

    // Reset held for five cycles
    rst_pix_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_line", line, 0);
    chk("rst_frame", frame, 0);
    chk("rst_sx", sx, H_STA);
    chk("rst_sy", sy, V_STA);

    // First edge after release
    rst_pix_n = 1'b1;
    step();
    chk("first_sx", sx, -160);
    chk("first_sy", sy, -45);
    chk("first_frame", frame, 1);
    chk("first_line", line, 1);

    // A full frame plus the start of the next one
    for (int i = 0; i < FRAME_LEN + LINE_LEN + 4; i++) step();
    chk("frames_seen", frames_seen, 2);
    chk("vs_runs", vs_runs, 1);
    chk("hs_runs_ge_line", (hs_runs >= V_RES + V_FP + V_SYNC + V_BP) ? 1 : 0, 1);

    // Reset in the middle of the active area
    found = 1'b0;
    for (int i = 0; i < FRAME_LEN && !found; i++) begin
      step();
      if (sx == 30 && sy == 5) found = 1'b1;
    end
    chk("seek_pos", found, 1);
    rst_pix_n = 1'b0;
    step();
    chk("midrst_sx", sx, H_STA);
    chk("midrst_sy", sy, V_STA);
    chk("midrst_de", de, 0);
    rst_pix_n = 1'b1;
    step();
    chk("post_rel_frame", frame, 1);
    chk("post_rel_sx", sx, H_STA);
    for (int i = 0; i < 3; i++) step();
    chk("post_rel_sx3", sx, H_STA + 3);

`ifdef DISPLAY_FRAME_CNT_EN
    rst_pix_n = 1'b0;
    step();
    step();
    chk("cnt_rst", frame_cnt, 0);
    rst_pix_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 3 * FRAME_LEN + 10 && npulse < 3; i++) begin
      step();
      if (frame) npulse++;
    end
    chk("cnt_pulses", npulse, 3);
    step();
    step();
    chk("cnt_after3", frame_cnt, 3);
`else
    npulse = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #(64'd2_000_000);
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_display_timing_480p
`default_nettype wire
